// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//
// Multi-channel input debouncer for mechanical buttons and slow serial lines
// (PS/2 clock/data and similar). Each channel is synchronised into the clk
// domain, then a per-channel counter measures how long the synchronised value
// has been stable. The counter only advances on cycles where tick is high, so
// the debounce window is (2^CNT_WIDTH - 1) ticks. A change is accepted only
// after the input has been stable for the whole window.
//
// Parameters
//   CHANNELS    number of independent channels (1..16)
//   CNT_WIDTH   stability counter width; threshold MAX = 2^CNT_WIDTH - 1
//   SYNC_STAGES synchroniser depth per channel (2..4)
//   INIT_LEVEL  reset value of every debounced level bit (0 or 1)
//
// Ports
//   clk    sole clock, everything on the rising edge
//   rst_n  synchronous active-low reset
//   tick   count enable for the stability counters
//   din    raw asynchronous inputs, one bit per channel
//   level  debounced level per channel (registered)
//   rise   one-cycle pulse in the first cycle level shows a 0->1 change
//   fall   one-cycle pulse in the first cycle level shows a 1->0 change
//
// Build option
//   DEBOUNCE_EDGE_EN  when defined, rise/fall are generated. When undefined,
//                     the rise/fall ports still exist but are tied to 0 and
//                     the edge registers are not built. level behaves the
//                     same either way.
//
// There is no handshake on this block: din is sampled every cycle, and
// level/rise/fall are plain registered outputs valid every cycle after reset.
// -----------------------------------------------------------------------------
module debounce_multi #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 7,
  parameter int SYNC_STAGES = 2,
  parameter int INIT_LEVEL  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  // Stability threshold: the counter saturates here and never wraps.
  localparam logic [CNT_WIDTH-1:0] MAX      = '1;
  localparam logic                 INIT_BIT = (INIT_LEVEL != 0);
  localparam logic [CHANNELS-1:0]  INIT_VEC = {CHANNELS{INIT_BIT}};

  // Synchroniser chain; stage 0 is the metastability-catching flop.
  logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
  // s: synchronised value; p: s one cycle later.
  logic [CHANNELS-1:0]  s;
  logic [CHANNELS-1:0]  p_q;
  // Per-channel stability counters.
  logic [CNT_WIDTH-1:0] cnt_q  [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d  [CHANNELS];
  // Debounced level and the per-channel "accept the new value" strobe.
  logic [CHANNELS-1:0]  level_q;
  logic [CHANNELS-1:0]  stable;
  logic [CHANNELS-1:0]  load;

  assign s      = sync_q[SYNC_STAGES-1];
  assign stable = ~(s ^ p_q);

  // ---------------------------------------------------------------------------
  // Synchroniser and one-cycle delay. Reset forces the whole chain and p to
  // the initial level so no spurious disagreement appears after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= INIT_VEC;
      end
      p_q <= INIT_VEC;
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      p_q <= s;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter next-state and level-load decision, per channel.
  // A disagreement between s and p always wins: the count restarts even if
  // the counter had already reached MAX, so a change arriving at MAX can never
  // be accepted before it has itself been stable for a full window.
  // The level load uses the current counter value, so it needs no tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    load = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      load[i]  = (cnt_q[i] == MAX) && stable[i] && (p_q[i] != level_q[i]);
      if (!stable[i]) begin
        cnt_d[i] = '0;
      end else if (tick && (cnt_q[i] != MAX)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= INIT_VEC;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q <= (level_q & ~load) | (p_q & load);
    end
  end

  assign level = level_q;

  // ---------------------------------------------------------------------------
  // Edge pulses. They are registered from the same load strobe that updates
  // level, so a pulse is visible in exactly the cycle the new level first
  // appears. Since a load always flips level toward p, at most one of
  // rise/fall can be set for a channel.
  // ---------------------------------------------------------------------------
`ifdef DEBOUNCE_EDGE_EN
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= load & p_q;
      fall_q <= load & ~p_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
//
// Directed bench for debounce_multi at default parameters. A reference model
// describes each channel as a delay line over the sampled din history (the
// synchronised value is din as sampled SYNC_STAGES-1 edges earlier, p one
// edge older than that) plus a saturating "ticks since last disagreement"
// count. A compare process checks level/rise/fall against the model on every
// falling edge, and the directed sequence pins the model with hand-computed
// latencies and output vectors.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

  localparam int   CH   = 4;
  localparam int   CW   = 7;
  localparam int   SS   = 2;
  localparam int   MAXC = (1 << CW) - 1;
  localparam logic INIT_B = 1'b0;
`ifdef DEBOUNCE_EDGE_EN
  localparam bit   EDGE = 1'b1;
`else
  localparam bit   EDGE = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick  = 1'b0;
  logic [CH-1:0] din   = '0;
  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  always #5 clk = ~clk;

  debounce_multi #(
    .CHANNELS   (CH),
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(SS),
    .INIT_LEVEL (0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .din  (din),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [CH-1:0] din_at[$];      // din sampled at edge k is din_at[k]
  int            last_rst = -1;  // most recent edge with rst_n low
  int            edge_n   = 0;
  int            m_cnt [CH];
  logic [CH-1:0] m_lvl  = '0;
  logic [CH-1:0] m_rise = '0;
  logic [CH-1:0] m_fall = '0;
  bit            cmp_en = 1'b0;

  // Value of channel ch as sampled at edge idx; anything at or before the
  // latest reset reads as the initial level.
  function automatic logic samp(input int idx, input int ch);
    if (idx < 0 || idx <= last_rst) return INIT_B;
    return din_at[idx][ch];
  endfunction

  always @(posedge clk) begin : model
    logic s_pre, p_pre;
    for (int ch = 0; ch < CH; ch++) begin
      // After edge n the synchronised value is the sample from edge n-SS+1,
      // so just before edge n it is the sample from edge n-SS.
      s_pre = samp(edge_n - SS, ch);
      p_pre = samp(edge_n - SS - 1, ch);
      if (!rst_n) begin
        m_cnt[ch]  = 0;
        m_lvl[ch]  = INIT_B;
        m_rise[ch] = 1'b0;
        m_fall[ch] = 1'b0;
      end else begin
        m_rise[ch] = 1'b0;
        m_fall[ch] = 1'b0;
        if (m_cnt[ch] == MAXC && s_pre == p_pre && p_pre != m_lvl[ch]) begin
          m_lvl[ch]  = p_pre;
          m_rise[ch] = EDGE & p_pre;
          m_fall[ch] = EDGE & ~p_pre;
        end
        if (s_pre != p_pre) m_cnt[ch] = 0;
        else if (tick)      m_cnt[ch] = (m_cnt[ch] + 1 > MAXC) ? MAXC : m_cnt[ch] + 1;
      end
    end
    din_at.push_back(din);
    if (!rst_n) last_rst = edge_n;
    edge_n++;
    cmp_en = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("level_vs_model", 32'(level), 32'(m_lvl));
      check("rise_vs_model",  32'(rise),  32'(m_rise));
      check("fall_vs_model",  32'(fall),  32'(m_fall));
      check("rise_fall_excl", 32'(rise & fall), 32'(0));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  bit quarter = 1'b0;
  int cyc     = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tick = quarter ? ((cyc % 4) == 0) : 1'b1;
  endtask

  // Counts edges until level[ch] == val; budget+1 on timeout.
  task automatic wait_ch(input int ch, input logic val, input int budget, output int edges);
    edges = budget + 1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (level[ch] === val) begin
        edges = k;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int e;
    rst_n = 1'b0;
    tick  = 1'b1;
    din   = '0;
    step();
    step();
    rst_n = 1'b1;
    check("reset_level", 32'(level), 32'(0));
    check("reset_rise",  32'(rise),  32'(0));
    check("reset_fall",  32'(fall),  32'(0));
    repeat (10) step();

    // Channel 0 rises after 131 edges, one-cycle rise pulse.
    din[0] = 1'b1;
    wait_ch(0, 1'b1, 200, e);
    check("A_latency",  32'(e),     32'(131));
    check("A_rise",     32'(rise),  EDGE ? 32'h1 : 32'h0);
    check("A_fall",     32'(fall),  32'(0));
    step();
    check("A_rise_clr", 32'(rise),  32'(0));
    check("A_level",    32'(level), 32'h1);

    // Channel 1 glitch of 100 cycles is shorter than the window.
    din[1] = 1'b1;
    repeat (100) step();
    din[1] = 1'b0;
    repeat (250) step();
    check("B_level", 32'(level), 32'h1);

    // Channel 2 with tick one cycle in four: roughly 4x slower.
    quarter = 1'b1;
    din[2]  = 1'b1;
    wait_ch(2, 1'b1, 700, e);
    check("C_latency_min", 32'(e >= 4 * MAXC),      32'(1));
    check("C_latency_max", 32'(e <= 4 * MAXC + 12), 32'(1));
    quarter = 1'b0;
    repeat (5) step();
    check("C_level", 32'(level), 32'h5);

    // Channels 0 and 3 change on the same cycle: same landing edge.
    din[0] = 1'b0;
    din[3] = 1'b1;
    wait_ch(3, 1'b1, 200, e);
    check("D_latency", 32'(e),     32'(131));
    check("D_level",   32'(level), 32'hC);
    check("D_rise",    32'(rise),  EDGE ? 32'h8 : 32'h0);
    check("D_fall",    32'(fall),  EDGE ? 32'h1 : 32'h0);
    repeat (5) step();

    // Reset at count 60 of a pending change on channel 1.
    din[1] = 1'b1;
    repeat (63) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("E_level_rst", 32'(level), 32'(0));
    check("E_rise_rst",  32'(rise),  32'(0));
    check("E_fall_rst",  32'(fall),  32'(0));
    wait_ch(1, 1'b1, 200, e);
    check("E_latency", 32'(e),     32'(131));
    check("E_level",   32'(level), 32'hE);
    check("E_rise",    32'(rise),  EDGE ? 32'hE : 32'h0);
    repeat (5) step();

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
